// File: rtl/alu_seq_unit.sv
// ----------------------------------------------------------------------------
// alu_seq_unit
//
// 8-bit ALU with a registered result/flags interface. Ops 0-14 finish in one
// clock. Op 15 (MUL) runs a shift-add multiplier for eight clocks, holding busy
// high while it runs.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   start    in   1  launch an op; ignored while busy=1
//   fun_sel  in   4  op code, sampled with start
//   a        in   8  operand A (register-file O1), sampled with start
//   b        in   8  operand B (register-file O2), sampled with start
//   result   out  8  registered result, held between completions
//   flags    out  4  registered {Z,C,N,O}
//   busy     out  1  multiply in progress
//   done     out  1  one-cycle pulse when result/flags were just written
// ----------------------------------------------------------------------------
module alu_seq_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] fun_sel,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic       busy,
    output logic       done
);

    // Flag bit positions inside flags.
    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_N = 1;
    localparam int F_O = 0;

    localparam logic [3:0] OP_A    = 4'd0;
    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_NA   = 4'd2;
    localparam logic [3:0] OP_NB   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADC  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_LSL  = 4'd10;
    localparam logic [3:0] OP_LSR  = 4'd11;
    localparam logic [3:0] OP_ASR  = 4'd12;
    localparam logic [3:0] OP_ROL  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  cnt_q,    cnt_d;
    logic [7:0]  opa_q,    opa_d;
    logic [7:0]  opb_q,    opb_d;
    logic [15:0] acc_q,    acc_d;
    logic [7:0]  result_q, result_d;
    logic [3:0]  flags_q,  flags_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath, driven straight from the input operands.
    // ------------------------------------------------------------------
    logic       c_in;       // carry registered before this op
    logic [7:0] addend;     // b, or ~b for subtract
    logic       add_cin;
    logic [8:0] add_sum;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_o;
    logic       upd_c;      // op writes C
    logic       upd_o;      // op writes O

    assign c_in = flags_q[F_C];

    always_comb begin
        addend  = b;
        add_cin = 1'b0;
        if (fun_sel == OP_ADC) begin
            add_cin = c_in;
        end else if (fun_sel == OP_SUB) begin
            // A-B as A+~B+1, so carry-out is the inverted borrow.
            addend  = ~b;
            add_cin = 1'b1;
        end
        add_sum = {1'b0, a} + {1'b0, addend} + {8'h00, add_cin};
    end

    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        upd_c   = 1'b0;
        upd_o   = 1'b0;
        unique case (fun_sel)
            OP_A:   alu_res = a;
            OP_B:   alu_res = b;
            OP_NA:  alu_res = ~a;
            OP_NB:  alu_res = ~b;
            OP_ADD, OP_ADC, OP_SUB: begin
                alu_res = add_sum[7:0];
                alu_c   = add_sum[8];
                // Signed overflow: like-signed inputs, differently signed sum.
                alu_o   = (a[7] == addend[7]) && (add_sum[7] != a[7]);
                upd_c   = 1'b1;
                upd_o   = 1'b1;
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_LSL: begin
                alu_res = {a[6:0], 1'b0};
                alu_c   = a[7];
                upd_c   = 1'b1;
            end
            OP_LSR: begin
                alu_res = {1'b0, a[7:1]};
                alu_c   = a[0];
                upd_c   = 1'b1;
            end
            OP_ASR: begin
                alu_res = {a[7], a[7:1]};
                alu_c   = a[0];
                upd_c   = 1'b1;
            end
            OP_ROL: begin
                alu_res = {a[6:0], c_in};
                alu_c   = a[7];
                upd_c   = 1'b1;
            end
            OP_ROR: begin
                alu_res = {c_in, a[7:1]};
                alu_c   = a[0];
                upd_c   = 1'b1;
            end
            default: alu_res = 8'h00;  // MUL goes through the sequencer
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier step: step k adds A<<k when B[k] is set.
    // ------------------------------------------------------------------
    logic [15:0] pp;
    logic [15:0] acc_sum;

    always_comb begin
        pp      = opb_q[cnt_q] ? ({8'h00, opa_q} << cnt_q) : 16'h0000;
        acc_sum = acc_q + pp;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (fun_sel == OP_MUL) begin
                        state_d = S_MUL;
                        opa_d   = a;
                        opb_d   = b;
                        acc_d   = 16'h0000;
                        cnt_d   = 3'd0;
                        busy_d  = 1'b1;
                    end else begin
                        result_d       = alu_res;
                        flags_d[F_Z]   = (alu_res == 8'h00);
                        flags_d[F_C]   = upd_c ? alu_c : flags_q[F_C];
                        flags_d[F_N]   = alu_res[7];
                        flags_d[F_O]   = upd_o ? alu_o : flags_q[F_O];
                        done_d         = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // start is ignored here; operands stay as latched.
                acc_d = acc_sum;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d      = S_IDLE;
                    cnt_d        = 3'd0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    result_d     = acc_sum[7:0];
                    flags_d[F_Z] = (acc_sum[7:0] == 8'h00);
                    flags_d[F_C] = (acc_sum[15:8] != 8'h00);
                    flags_d[F_N] = acc_sum[7];
                    flags_d[F_O] = flags_q[F_O];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; reset wins over start and aborts a running MUL.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            acc_q    <= 16'h0000;
            result_q <= 8'h00;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_unit
//
// Directed vectors with hand-computed results. Each issued op pushes its
// expected {result, flags} into a scoreboard queue; a monitor on the falling
// edge pops and compares whenever done is high. Timing (done width, busy
// window, reset abort) is checked inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] fun_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int op_id    = 0;

    typedef struct {
        int         id;
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fun_sel(fun_sel),
        .a      (a),
        .b      (b),
        .result (result),
        .flags  (flags),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done_with_empty_queue expected=no_done");
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_result", e.id), 16'(result), 16'(e.r));
                check($sformatf("op%0d_flags", e.id), 16'(flags), 16'(e.f));
            end
        end
    end

    // Drive one start pulse; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] fs, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] er, input logic [3:0] ef, input bit push);
        fun_sel = fs;
        a       = av;
        b       = bv;
        start   = 1'b1;
        if (push) sb.push_back('{op_id, er, ef});
        op_id++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic single(input logic [3:0] fs, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] er, input logic [3:0] ef);
        issue(fs, av, bv, er, ef, 1'b1);
        check($sformatf("op%0d_done_busy_e0", op_id - 1), 16'({busy, done}), 16'h1);
        @(posedge clk);
        #1;
        check($sformatf("op%0d_done_fall", op_id - 1), 16'(done), 16'h0);
    endtask

    // MUL: busy after E0..E7, done/busy=0 after E8. poke drives a start
    // sampled at E3 that must be ignored.
    task automatic mul(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] er, input logic [3:0] ef, input bit poke);
        issue(4'd15, av, bv, er, ef, 1'b1);
        check("mul_busy_e0", 16'({busy, done}), 16'h2);
        for (int i = 1; i <= 7; i++) begin
            if (poke && i == 3) begin
                start   = 1'b1;
                fun_sel = 4'd0;
                a       = 8'hAA;
                b       = 8'h55;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("mul_busy_e%0d", i), 16'({busy, done}), 16'h2);
        end
        @(posedge clk);
        #1;
        check("mul_done_e8", 16'({busy, done}), 16'h1);
    endtask

    initial begin : stim
        bit saw_done;
        // Reset with start high: reset must win.
        rst_n   = 1'b0;
        start   = 1'b1;
        fun_sel = 4'd4;
        a       = 8'h01;
        b       = 8'h01;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        check("reset_result", 16'(result), 16'h00);
        check("reset_flags", 16'(flags), 16'h0);
        check("reset_busy_done", 16'({busy, done}), 16'h0);

        // flags = {Z,C,N,O}
        single(4'd4,  8'h7F, 8'h01, 8'h80, 4'b0011);  // ADD signed overflow
        single(4'd6,  8'h05, 8'h05, 8'h00, 4'b1100);  // SUB equal, no borrow
        single(4'd7,  8'hF0, 8'h0F, 8'h00, 4'b1100);  // AND, C/O held
        single(4'd13, 8'h80, 8'h00, 8'h01, 4'b0100);  // ROL through C=1
        single(4'd14, 8'h01, 8'h00, 8'h80, 4'b0110);  // ROR through C=1
        single(4'd4,  8'h7F, 8'h01, 8'h80, 4'b0011);  // set O=1, C=0
        mul(8'h10, 8'h11, 8'h10, 4'b0101, 1'b1);      // 0x110: C=1, O held
        single(4'd5,  8'hFF, 8'h00, 8'h00, 4'b1100);  // ADC with C=1 wraps
        single(4'd8,  8'h80, 8'h01, 8'h81, 4'b0110);  // OR
        single(4'd9,  8'hAA, 8'hAA, 8'h00, 4'b1100);  // XOR
        single(4'd11, 8'h03, 8'h00, 8'h01, 4'b0100);  // LSR
        single(4'd12, 8'h81, 8'h00, 8'hC0, 4'b0110);  // ASR keeps sign
        single(4'd10, 8'h40, 8'h00, 8'h80, 4'b0010);  // LSL, C=0
        single(4'd2,  8'hFF, 8'h00, 8'h00, 4'b1000);  // ~A
        single(4'd3,  8'h00, 8'h0F, 8'hF0, 4'b0010);  // ~B
        single(4'd0,  8'h55, 8'h00, 8'h55, 4'b0000);  // A
        single(4'd1,  8'h00, 8'h00, 8'h00, 4'b1000);  // B
        mul(8'h0F, 8'h03, 8'h2D, 4'b0000, 1'b0);      // no high byte, C=0
        // Issued in the MUL's done cycle: must be accepted.
        single(4'd6,  8'h80, 8'h01, 8'h7F, 4'b0101);  // SUB signed overflow

        // Reset at E4 of a MUL: abort, no done.
        issue(4'd15, 8'h10, 8'h11, 8'h00, 4'b0000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rstmul_busy_done", 16'({busy, done}), 16'h0);
        check("rstmul_result", 16'(result), 16'h00);
        check("rstmul_flags", 16'(flags), 16'h0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (busy !== 1'b0) saw_done = 1'b1;
        end
        check("rstmul_no_done_no_busy", 16'(saw_done), 16'h0);
        @(posedge clk);
        #1;
        single(4'd4, 8'h01, 8'h01, 8'h02, 4'b0000);   // accepted after abort

        @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
